fsm_input_conditioner: RTL
==========================

// Module: fsm_input_conditioner
// PURPOSE
// - Upstream stage of the two-input control FSM. Conditions two asynchronous raw inputs (buttons or external lines).
// - Each channel: synchronise -> debounce -> detect edges. Delivers clean single-cycle pulses (input_sig_1/2 of the FSM) plus debounced levels.
// - Two identical, independent channels; one instance sits between chip pins and the FSM.
// PARAMETERS
// - SYNC_STAGES      2  synchroniser flop count per channel; legal >= 2
// - DEBOUNCE_CYCLES  4  consecutive stable synchronised samples required to accept a level change; legal >= 2
// - GLITCH_W         8  width of glitch counters (used only with FSM_IN_GLITCH_CNT_EN)
// - localparam CNT_W = $clog2(DEBOUNCE_CYCLES)
// PORTS
// - clk          in   1         clock, all logic rising-edge
// - rst          in   1         synchronous, active-high reset
// - raw_1        in   1         asynchronous raw input, channel 1
// - raw_2        in   1         asynchronous raw input, channel 2
// - en           in   1         1 = pulse outputs enabled; 0 = pulses forced 0, levels keep tracking
// - sig_1        out  1         1-cycle pulse on accepted rising edge, ch1 (drives FSM input_sig_1)
// - sig_2        out  1         1-cycle pulse on accepted rising edge, ch2 (drives FSM input_sig_2)
// - lvl_1        out  1         debounced level, ch1
// - lvl_2        out  1         debounced level, ch2
// - glitch_cnt_1 out  GLITCH_W  aborted transitions, ch1 (macro only)
// - glitch_cnt_2 out  GLITCH_W  aborted transitions, ch2 (macro only)
// BEHAVIOUR
// - Reset, per channel: sync chain = 0, state = S_LOW, counter = 0. Outputs: sig = 0, lvl = 0, glitch_cnt = 0.
// - Reset asserted mid-count aborts the transition. No pulse is emitted and no glitch is counted.
// - Synchroniser: raw_x feeds SYNC_STAGES flops. Only the last stage (s_x) is used by logic.
// - Channel FSM (registered state, counter cnt):
//   - S_LOW:  s=1 -> S_RISE, cnt=1.
//   - S_RISE: s=0 -> S_LOW, cnt=0, glitch++.
//             s=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, lvl<=1, sig<=en.
//             otherwise cnt++.
//   - S_HIGH: s=0 -> S_FALL, cnt=1.
//   - S_FALL: s=1 -> S_HIGH, cnt=0, glitch++.
//             s=0 and cnt==DEBOUNCE_CYCLES-1 -> S_LOW, lvl<=0 (no pulse on falling edge).
//             otherwise cnt++.
//   - Illegal state encoding -> S_LOW next cycle, sig=0.
// - Latency: let e be the first edge at which raw is sampled high, with raw held high afterwards.
//   - sig is high for exactly the one cycle following edge e+SYNC_STAGES+DEBOUNCE_CYCLES-1.
//   - lvl rises on that same edge. Default params: sig after edge e+5.
//   - The falling-edge path has identical latency for lvl.
// - sig is registered and never asserted for 2 consecutive cycles; it re-asserts only after a full fall and rise.
// - en is sampled at the accepting edge only. A rise accepted while en=0 gives no pulse later.
// - Channels are fully independent. sig_1 and sig_2 may assert in the same cycle; priority is resolved downstream.
// - Glitch counters saturate at all-ones, with no wrap.
// CONFIGURATION
// - Macro FSM_IN_GLITCH_CNT_EN defined:
//   - glitch_cnt_1/2 ports and counters exist.
//   - Each counter increments on every aborted S_RISE or S_FALL, and saturates.
// - Macro undefined: ports and counters absent. All other behaviour unchanged.
// STRUCTURE
// - Package fsm_in_pkg holds:
//   - typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} deb_state_t
//   - default-parameter constants.
// - Sub-module deb_channel: sync chain + FSM + counter + optional glitch counter, one per channel.
// - Top instantiates deb_channel twice.
// TESTING
// - Reset: rst=1 for 2 cycles with raw_1=raw_2=1 -> sig=lvl=0 during reset; after release, sig_1 pulses once at edge 6.
// - Clean edge: raw_1 0->1 held 10 cycles, en=1 -> one sig_1 pulse after edge e+5, lvl_1=1 from then on.
// - Bounce: raw_1 high 2 cycles, low 1, high 10 -> exactly one sig_1 pulse, glitch_cnt_1=1 (macro on).
// - Both channels: raw_1 and raw_2 rise on the same edge -> sig_1 and sig_2 pulse in the same cycle, one cycle wide.
// - Enable gating: en=0 at acceptance -> lvl_1=1, no sig_1. Fall, then rise again with en=1 -> one pulse.
// - Mid-count reset: raw_2 rises, rst asserted at cnt=2 -> state S_LOW, no pulse, glitch_cnt_2=0.

Source files
------------

// File: rtl/fsm_input_conditioner_pkg.sv
// Package fsm_in_pkg: shared types and default parameter values for the
// two-channel input conditioner (fsm_input_conditioner / deb_channel).
//   deb_state_t          - debounce FSM state encoding
//   DEF_SYNC_STAGES      - default synchroniser depth
//   DEF_DEBOUNCE_CYCLES  - default number of stable samples to accept a change
//   DEF_GLITCH_W         - default glitch counter width
package fsm_in_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_GLITCH_W        = 8;

endpackage

// File: rtl/fsm_input_conditioner_deb_channel.sv
// deb_channel: one conditioning channel.
// The raw input goes through a synchroniser, then a debounce FSM, and the
// accepted rising edge comes out as a one-cycle pulse.
// Optional macro FSM_IN_GLITCH_CNT_EN adds a saturating count of aborted
// transitions.
// Ports:
//   clk, rst     - clock (rising edge), synchronous active-high reset
//   i_raw        - asynchronous raw input
//   i_en         - pulse enable, sampled on the accepting edge only
//   o_sig        - 1-cycle pulse on an accepted rising edge
//   o_lvl        - debounced level
//   o_glitch_cnt - aborted transitions, saturating (FSM_IN_GLITCH_CNT_EN only)
module deb_channel
  import fsm_in_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef FSM_IN_GLITCH_CNT_EN
  ,
  parameter int GLITCH_W        = DEF_GLITCH_W
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_en,
  output logic o_sig,
  output logic o_lvl
`ifdef FSM_IN_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] o_glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // The sample that moves the FSM out of S_LOW/S_HIGH already counts as 1,
  // so DEBOUNCE_CYCLES-1 is the last value seen before acceptance.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  deb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_lvl, w_lvl_nxt;
  logic             r_sig, w_sig_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_sig   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lvl   <= w_lvl_nxt;
      r_sig   <= w_sig_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lvl_nxt   = r_lvl;
    w_sig_nxt   = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_s) begin
          w_state_nxt = S_RISE;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_RISE: begin
        if (!w_s) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
          w_lvl_nxt   = 1'b1;
          w_sig_nxt   = i_en;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!w_s) begin
          w_state_nxt = S_FALL;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_FALL: begin
        if (w_s) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
          w_lvl_nxt   = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
        w_lvl_nxt   = 1'b0;
      end
    endcase
  end

  assign o_sig = r_sig;
  assign o_lvl = r_lvl;

`ifdef FSM_IN_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch;
  logic                w_abort;

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A pending transition is aborted when the sample returns to the old level.
  assign w_abort = ((r_state == S_RISE) && !w_s) || ((r_state == S_FALL) && w_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch <= '0;
    end else if (w_abort) begin
      r_glitch <= sat_inc(r_glitch);
    end
  end

  assign o_glitch_cnt = r_glitch;
`endif

endmodule

// File: rtl/fsm_input_conditioner.sv
// fsm_input_conditioner: conditions two asynchronous raw inputs for the
// two-input control FSM. The channels are identical and independent. Each one
// runs synchronise -> debounce -> rising-edge pulse.
// Optional macro FSM_IN_GLITCH_CNT_EN adds the glitch_cnt_1/2 ports.
// Ports:
//   clk, rst       - clock (rising edge), synchronous active-high reset
//   raw_1, raw_2   - asynchronous raw inputs
//   en             - 1 enables pulses; levels track regardless
//   sig_1, sig_2   - 1-cycle pulses on accepted rising edges (FSM input_sig_1/2)
//   lvl_1, lvl_2   - debounced levels
//   glitch_cnt_1/2 - saturating aborted-transition counts (macro only)
module fsm_input_conditioner
  import fsm_in_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = DEF_GLITCH_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_1,
  input  logic raw_2,
  input  logic en,
  output logic sig_1,
  output logic sig_2,
  output logic lvl_1,
  output logic lvl_2
`ifdef FSM_IN_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt_1,
  output logic [GLITCH_W-1:0] glitch_cnt_2
`endif
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || GLITCH_W < 1) begin : g_param_check
    $error("fsm_input_conditioner: illegal parameter value");
  end

`ifdef FSM_IN_GLITCH_CNT_EN
  deb_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .GLITCH_W       (GLITCH_W)
  ) u_ch1 (
    .clk         (clk),
    .rst         (rst),
    .i_raw       (raw_1),
    .i_en        (en),
    .o_sig       (sig_1),
    .o_lvl       (lvl_1),
    .o_glitch_cnt(glitch_cnt_1)
  );

  deb_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .GLITCH_W       (GLITCH_W)
  ) u_ch2 (
    .clk         (clk),
    .rst         (rst),
    .i_raw       (raw_2),
    .i_en        (en),
    .o_sig       (sig_2),
    .o_lvl       (lvl_2),
    .o_glitch_cnt(glitch_cnt_2)
  );
`else
  deb_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .i_raw(raw_1),
    .i_en (en),
    .o_sig(sig_1),
    .o_lvl(lvl_1)
  );

  deb_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch2 (
    .clk  (clk),
    .rst  (rst),
    .i_raw(raw_2),
    .i_en (en),
    .o_sig(sig_2),
    .o_lvl(lvl_2)
  );
`endif

endmodule
